// File: rtl/ram64_block_mover.sv
// Block copy / block fill engine driving the RAM64 port (64 x 16, combinational
// read, write on posedge when mem_load is high). Addresses wrap modulo 64.
module ram64_block_mover (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        mode,
    input  logic [5:0]  src,
    input  logic [5:0]  dst,
    input  logic [6:0]  len,
    input  logic [15:0] fill_data,
    output logic        busy,
    output logic        done,
    output logic [5:0]  mem_address,
    output logic [15:0] mem_in,
    output logic        mem_load,
    input  logic [15:0] mem_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state;
    logic [5:0]  src_ptr;
    logic [5:0]  dst_ptr;
    logic [6:0]  cnt;
    logic        mode_reg;
    logic [15:0] fill_reg;
    logic [15:0] data_reg;
    logic [6:0]  len_clamped;

    always_comb begin
        len_clamped = (len > 7'd64) ? 7'd64 : len;
    end

    // busy/done/mem_load are registered next to the state so they change on
    // the same edge as the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            src_ptr  <= '0;
            dst_ptr  <= '0;
            cnt      <= '0;
            mode_reg <= 1'b0;
            fill_reg <= '0;
            data_reg <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            mem_load <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        src_ptr  <= src;
                        dst_ptr  <= dst;
                        cnt      <= len_clamped;
                        mode_reg <= mode;
                        fill_reg <= fill_data;
                        if (len_clamped == 7'd0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else if (mode) begin
                            state    <= WRITE;
                            busy     <= 1'b1;
                            mem_load <= 1'b1;
                        end else begin
                            state <= READ;
                            busy  <= 1'b1;
                        end
                    end
                end
                READ: begin
                    data_reg <= mem_out;
                    state    <= WRITE;
                    mem_load <= 1'b1;
                end
                WRITE: begin
                    dst_ptr <= dst_ptr + 6'd1;
                    if (!mode_reg) begin
                        src_ptr <= src_ptr + 6'd1;
                    end
                    cnt <= cnt - 7'd1;
                    if (cnt == 7'd1) begin
                        state    <= DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        mem_load <= 1'b0;
                    end else if (mode_reg) begin
                        state <= WRITE;
                    end else begin
                        state    <= READ;
                        mem_load <= 1'b0;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                    mem_load <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        mem_address = '0;
        mem_in      = '0;
        case (state)
            READ:  mem_address = src_ptr;
            WRITE: begin
                mem_address = dst_ptr;
                mem_in      = mode_reg ? fill_reg : data_reg;
            end
            default: begin
                mem_address = '0;
                mem_in      = '0;
            end
        endcase
    end

endmodule
